// File: rtl/uart_frame_loader_pkg.sv
// Shared definitions for the UART parameter-frame loader and its host-side test model.
package uart_frame_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CSUM    = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [7:0] SOF_BYTE    = 8'hAA;
    localparam int         TIMEOUT_DEF = 50000;

endpackage

// File: rtl/uart_frame_loader_if.sv
// Byte-in / RAM-write-out bundle of the frame loader; slave is the loader, master the host side.
interface uart_frame_loader_if #(
    parameter int ADDR_W = 3
);
    logic [7:0]        rx_data;
    logic              rx_done;
    logic [7:0]        ram_in;
    logic [ADDR_W-1:0] ram_w_addr;
    logic              ram_CS;
    logic              busy;
    logic              load_done;
    logic              frame_err;

    modport master (
        output rx_data, rx_done,
        input  ram_in, ram_w_addr, ram_CS, busy, load_done, frame_err
    );

    modport slave (
        input  rx_data, rx_done,
        output ram_in, ram_w_addr, ram_CS, busy, load_done, frame_err
    );
endinterface

// File: rtl/uart_frame_loader_frame_timeout_cnt.sv
// Inter-byte idle counter: expired pulses on the clock that would bring the count to TIMEOUT_CYC.
module frame_timeout_cnt
    import uart_frame_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

    logic [W-1:0] cnt;

    // clr outranks the expiry so a byte landing on the boundary clock still counts as in time
    assign expired = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_frame_loader.sv
// Parses header/payload/checksum frames into a shadow buffer and bursts them to the parameter RAM on a good checksum.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int         N_BYTES     = 8,
    parameter int         ADDR_W      = $clog2(N_BYTES),
    parameter logic [7:0] HEADER      = SOF_BYTE,
    parameter int         TIMEOUT_CYC = TIMEOUT_DEF
) (
    input logic             clk,
    input logic             rst,
    uart_frame_loader_if.slave bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BYTES - 1);

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [7:0]              sum, sum_n;
    logic [N_BYTES-1:0][7:0] shadow;
    logic                    shadow_we;
    logic [7:0]              ram_in_n;
    logic [ADDR_W-1:0]       addr_n, nxt_idx;
    logic                    cs_n, busy_n, done_n, err_n;
    logic                    in_frame, expired;

    assign in_frame = (state == PAYLOAD) || (state == CSUM);
    assign nxt_idx  = ADDR_W'(cnt + 1'b1);

    frame_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.rx_done || !in_frame),
        .en      (in_frame),
        .expired (expired)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sum_n     = sum;
        ram_in_n  = bus.ram_in;
        addr_n    = bus.ram_w_addr;
        cs_n      = 1'b1;
        busy_n    = bus.busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        shadow_we = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_done && bus.rx_data == HEADER) begin
                    state_n = PAYLOAD;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    sum_n   = '0;
                end
            end
            PAYLOAD: begin
                if (expired) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    err_n   = 1'b1;
                end else if (bus.rx_done) begin
                    shadow_we = 1'b1;
                    sum_n     = sum + bus.rx_data;
                    cnt_n     = cnt + 1'b1;
                    if (cnt == LAST) state_n = CSUM;
                end
            end
            CSUM: begin
                if (expired || (bus.rx_done && bus.rx_data != sum)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    err_n   = 1'b1;
                end else if (bus.rx_done) begin
                    // first write is presented straight off the checksum edge
                    state_n  = COMMIT;
                    cnt_n    = '0;
                    cs_n     = 1'b0;
                    addr_n   = '0;
                    ram_in_n = shadow[0];
                end
            end
            COMMIT: begin
                if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n    = cnt + 1'b1;
                    cs_n     = 1'b0;
                    addr_n   = nxt_idx;
                    ram_in_n = shadow[nxt_idx];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            sum            <= '0;
            bus.ram_in     <= '0;
            bus.ram_w_addr <= '0;
            bus.ram_CS     <= 1'b1;
            bus.busy       <= 1'b0;
            bus.load_done  <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            sum            <= sum_n;
            bus.ram_in     <= ram_in_n;
            bus.ram_w_addr <= addr_n;
            bus.ram_CS     <= cs_n;
            bus.busy       <= busy_n;
            bus.load_done  <= done_n;
            bus.frame_err  <= err_n;
        end
    end

    // shadow is deliberately left out of reset; it is always refilled before a commit
    always_ff @(posedge clk) begin
        if (shadow_we) shadow[cnt[ADDR_W-1:0]] <= bus.rx_data;
    end
endmodule
